// File: rtl/multicycle_controller.sv
// Main control FSM for the RV32 multicycle core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and decodes the ALU operation.
module multicycle_controller #(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] AluControl,
    output logic       instr_done,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        JAL,
        BEQ,
        TRAP
    } state_t;

    state_t state;
    state_t next_state;

    logic       supported;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       done;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    always_comb begin
        supported = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BEQ, OP_JAL: supported = 1'b1;
            default:                                         supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC_R;
                    OP_IALU:      next_state = EXEC_I;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = (ILLEGAL_TRAP != 0) ? TRAP : FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = FETCH;
            EXEC_R:   next_state = ALUWB;
            EXEC_I:   next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            JAL:      next_state = ALUWB;
            BEQ:      next_state = FETCH;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        done       = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                done      = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b01;
                branch    = 1'b1;
                done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Subtract only for R-type with funct7b5; I-type addi keeps ADD whatever imm[10] is.
    always_comb begin
        AluControl = 3'b000;
        case (alu_op)
            2'b00: AluControl = 3'b000;
            2'b01: AluControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  AluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  AluControl = 3'b101;
                    3'b110:  AluControl = 3'b011;
                    3'b111:  AluControl = 3'b010;
                    default: AluControl = 3'b000;
                endcase
            end
            default: AluControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Strobes are gated by rst_n so nothing writes while reset is held.
    assign PCWrite       = rst_n & (pc_update | (branch & Zero));
    assign IRWrite       = rst_n & ir_write;
    assign RegWrite      = rst_n & reg_write;
    assign MemWrite      = rst_n & mem_write;
    assign instr_done    = rst_n & done;
    assign illegal_instr = rst_n & (state == DECODE) & ~supported;
    assign AdrSrc        = adr_src;
    assign ResultSrc     = result_src;
    assign ALUSrcA       = alu_src_a;
    assign ALUSrcB       = alu_src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one trap-mode and one skip-mode
// instance driven by the same instruction fields.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] AluControl;

    logic       PCWrite_s, AdrSrc_s, MemWrite_s, IRWrite_s, RegWrite_s, instr_done_s, illegal_instr_s;
    logic [1:0] ResultSrc_s, ALUSrcA_s, ALUSrcB_s, ImmSrc_s;
    logic [2:0] AluControl_s;

    int numChecks = 0;
    int numPassed = 0;

    multicycle_controller #(.ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .AluControl(AluControl), .instr_done(instr_done),
        .illegal_instr(illegal_instr)
    );

    multicycle_controller #(.ILLEGAL_TRAP(0)) dut_skip (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite_s), .AdrSrc(AdrSrc_s), .MemWrite(MemWrite_s), .IRWrite(IRWrite_s),
        .RegWrite(RegWrite_s), .ResultSrc(ResultSrc_s), .ALUSrcA(ALUSrcA_s), .ALUSrcB(ALUSrcB_s),
        .ImmSrc(ImmSrc_s), .AluControl(AluControl_s), .instr_done(instr_done_s),
        .illegal_instr(illegal_instr_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH and walks FETCH, DECODE, EXEC_R/EXEC_I, ALUWB back to FETCH.
    task automatic runAlu(input string name, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] expAlu, input logic [1:0] expSrcB);
        applyStimulus(o, f3, f7, 1'b0);
        checkOutput({name, " fetch IRWrite"}, IRWrite, 1);
        nextCycle();
        checkOutput({name, " decode AluControl"}, AluControl, 3'b000);
        nextCycle();
        checkOutput({name, " exec AluControl"}, AluControl, expAlu);
        checkOutput({name, " exec ALUSrcB"}, ALUSrcB, expSrcB);
        checkOutput({name, " exec ALUSrcA"}, ALUSrcA, 2'b10);
        checkOutput({name, " exec RegWrite"}, RegWrite, 0);
        nextCycle();
        checkOutput({name, " aluwb RegWrite"}, RegWrite, 1);
        checkOutput({name, " aluwb instr_done"}, instr_done, 1);
        nextCycle();
        checkOutput({name, " back to fetch"}, IRWrite, 1);
    endtask

    // Starts in FETCH, runs a beq to completion with the given Zero flag.
    task automatic runBeq(input string name, input logic z);
        applyStimulus(7'b1100011, 3'b000, 1'b0, z);
        nextCycle();
        checkOutput({name, " decode PCWrite"}, PCWrite, 0);
        checkOutput({name, " decode ImmSrc"}, ImmSrc, 2'b10);
        nextCycle();
        checkOutput({name, " beq PCWrite"}, PCWrite, {31'd0, z});
        checkOutput({name, " beq AluControl"}, AluControl, 3'b001);
        checkOutput({name, " beq ImmSrc"}, ImmSrc, 2'b10);
        checkOutput({name, " beq instr_done"}, instr_done, 1);
        nextCycle();
        checkOutput({name, " back to fetch"}, IRWrite, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);

        #12;
        checkOutput("reset IRWrite", IRWrite, 0);
        checkOutput("reset PCWrite", PCWrite, 0);
        checkOutput("reset ALUSrcB", ALUSrcB, 2'b10);
        checkOutput("reset ResultSrc", ResultSrc, 2'b10);

        // lw x5,8(x1): five states
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("lw fetch IRWrite", IRWrite, 1);
        checkOutput("lw fetch PCWrite", PCWrite, 1);
        nextCycle();
        checkOutput("lw decode ALUSrcA", ALUSrcA, 2'b01);
        checkOutput("lw decode ALUSrcB", ALUSrcB, 2'b01);
        checkOutput("lw decode IRWrite", IRWrite, 0);
        nextCycle();
        checkOutput("lw memadr ALUSrcA", ALUSrcA, 2'b10);
        checkOutput("lw memadr AdrSrc", AdrSrc, 0);
        nextCycle();
        checkOutput("lw memread AdrSrc", AdrSrc, 1);
        checkOutput("lw memread RegWrite", RegWrite, 0);
        nextCycle();
        checkOutput("lw memwb ResultSrc", ResultSrc, 2'b01);
        checkOutput("lw memwb RegWrite", RegWrite, 1);
        checkOutput("lw memwb instr_done", instr_done, 1);
        checkOutput("lw memwb ImmSrc", ImmSrc, 2'b00);
        nextCycle();
        checkOutput("lw back to fetch", IRWrite, 1);

        runAlu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00);
        runAlu("add",  7'b0110011, 3'b000, 1'b0, 3'b000, 2'b00);
        runAlu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 2'b01);
        runAlu("and",  7'b0110011, 3'b111, 1'b0, 3'b010, 2'b00);
        runAlu("or",   7'b0110011, 3'b110, 1'b0, 3'b011, 2'b00);
        runAlu("slt",  7'b0110011, 3'b010, 1'b0, 3'b101, 2'b00);
        runAlu("xor",  7'b0110011, 3'b100, 1'b0, 3'b000, 2'b00);

        runBeq("beq taken", 1'b1);
        runBeq("beq not taken", 1'b0);

        // jal
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("jal PCWrite", PCWrite, 1);
        checkOutput("jal ALUSrcA", ALUSrcA, 2'b01);
        checkOutput("jal ALUSrcB", ALUSrcB, 2'b10);
        checkOutput("jal ImmSrc", ImmSrc, 2'b11);
        checkOutput("jal RegWrite", RegWrite, 0);
        nextCycle();
        checkOutput("jal aluwb RegWrite", RegWrite, 1);
        checkOutput("jal aluwb instr_done", instr_done, 1);
        nextCycle();
        checkOutput("jal back to fetch", IRWrite, 1);

        // Unsupported opcode in both modes
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
        checkOutput("illegal fetch no pulse", illegal_instr, 0);
        nextCycle();
        checkOutput("illegal pulse trap", illegal_instr, 1);
        checkOutput("illegal pulse skip", illegal_instr_s, 1);
        nextCycle();
        checkOutput("skip back to fetch", IRWrite_s, 1);
        checkOutput("skip pulse cleared", illegal_instr_s, 0);
        for (int i = 0; i < 22; i++) begin
            checkOutput("trap strobes idle",
                        {PCWrite, IRWrite, RegWrite, MemWrite, instr_done, illegal_instr}, 6'd0);
            nextCycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("trap reset IRWrite", IRWrite, 0);
        #3;
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("trap released to fetch", IRWrite, 1);

        // sw, with reset dropped in the middle of MEMWRITE
        nextCycle();
        checkOutput("sw decode ImmSrc", ImmSrc, 2'b01);
        nextCycle();
        checkOutput("sw memadr ALUSrcB", ALUSrcB, 2'b01);
        nextCycle();
        checkOutput("sw memwrite MemWrite", MemWrite, 1);
        checkOutput("sw memwrite AdrSrc", AdrSrc, 1);
        checkOutput("sw memwrite instr_done", instr_done, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset MemWrite", MemWrite, 0);
        checkOutput("async reset instr_done", instr_done, 0);
        checkOutput("async reset AdrSrc", AdrSrc, 0);
        checkOutput("async reset ALUSrcB", ALUSrcB, 2'b10);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("post reset IRWrite", IRWrite, 1);
        nextCycle();
        checkOutput("post reset decode ALUSrcA", ALUSrcA, 2'b01);
        checkOutput("post reset decode IRWrite", IRWrite, 0);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
